// File: rtl/video_timing.sv
// video_timing: pixel-clock raster counters, strobes and display syncs.
// Display-side HSYNC/VSYNC/DE are delayed to line up with the colour path.
module video_timing #(
    parameter int  H_FRONT    = 16,
    parameter int  H_SYNC     = 96,
    parameter int  H_BACK     = 48,
    parameter int  H_VISIBLE  = 640,
    parameter int  V_VISIBLE  = 480,
    parameter int  V_FRONT    = 10,
    parameter int  V_SYNC     = 2,
    parameter int  V_BACK     = 33,
    parameter bit  H_SYNC_POL = 1'b0,
    parameter bit  V_SYNC_POL = 1'b0,
    parameter int  SYNC_DELAY = 4,
    parameter type hres_t     = logic [11:0],
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int V_W        = $clog2(V_TOTAL)
) (
    input  logic             clk,
    input  logic             reset,
    output hres_t            h_count_o,
    output logic [V_W-1:0]   v_count_o,
    output logic             v_visible_o,
    output logic             end_of_line_o,
    output logic             end_of_frame_o,
    output logic [15:0]      frame_count_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             dv_de_o
);

    localparam int H_OFFSCREEN = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL     = H_OFFSCREEN + H_VISIBLE;

    typedef logic [V_W-1:0] vres_t;

    localparam hres_t H_ONE     = hres_t'(1);
    localparam hres_t H_LAST    = hres_t'(H_TOTAL - 1);
    localparam hres_t H_SYNC_LO = hres_t'(H_FRONT);
    localparam hres_t H_SYNC_HI = hres_t'(H_FRONT + H_SYNC);
    localparam hres_t H_VIS_LO  = hres_t'(H_OFFSCREEN);

    localparam vres_t V_ONE     = vres_t'(1);
    localparam vres_t V_LAST    = vres_t'(V_TOTAL - 1);
    localparam vres_t V_VIS_END = vres_t'(V_VISIBLE);
    localparam vres_t V_SYNC_LO = vres_t'(V_VISIBLE + V_FRONT);
    localparam vres_t V_SYNC_HI = vres_t'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
        $error("video_timing: porch and sync widths must be >= 1");
    end

    if (H_TOTAL > (1 << $bits(hres_t))) begin : g_bad_hres
        $error("video_timing: H_TOTAL does not fit in hres_t");
    end

    if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
        $error("video_timing: SYNC_DELAY must be within 1..8");
    end

    hres_t       h_q;
    vres_t       v_q;
    logic [15:0] frame_q;
    logic [15:0] frame_next;
    logic        eol;
    logic        eof;
    logic        hs_raw;
    logic        vs_raw;
    logic        de_raw;
    logic [2:0]  pipe_q [SYNC_DELAY];
    logic [2:0]  pipe_tail;

    // Raster position: h wraps every line, v wraps after the last line.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + V_ONE;
        end else begin
            h_q <= h_q + H_ONE;
        end
    end

    // Strobes and undelayed display decodes, all from the count registers.
    always_comb begin
        eol        = (h_q == H_LAST);
        eof        = eol && (v_q == V_LAST);
        hs_raw     = (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI);
        vs_raw     = (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI);
        de_raw     = (h_q >= H_VIS_LO) && (v_q < V_VIS_END);
        frame_next = frame_q + {15'd0, eof};
    end

    // Completed-frame count; a reset on the last cycle of a frame wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_next;
        end
    end

    // Shift chain {hs, vs, de}; reset flushes every stage to inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                pipe_q[i] <= 3'b000;
            end
        end else begin
            pipe_q[0] <= {hs_raw, vs_raw, de_raw};
            for (int i = 1; i < SYNC_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_tail      = pipe_q[SYNC_DELAY-1];
    assign h_count_o      = h_q;
    assign v_count_o      = v_q;
    assign v_visible_o    = (v_q < V_VIS_END);
    assign end_of_line_o  = eol;
    assign end_of_frame_o = eof;
    assign frame_count_o  = frame_q;
    assign hsync_o        = pipe_tail[2] ? H_SYNC_POL : !H_SYNC_POL;
    assign vsync_o        = pipe_tail[1] ? V_SYNC_POL : !V_SYNC_POL;
    assign dv_de_o        = pipe_tail[0];

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: four video_timing builds checked every cycle against
// an arithmetic raster model, plus a schedule of hand-computed values.
module tb_video_timing;

    logic       clk = 1'b0;
    logic [3:0] rst = 4'b0000;

    always #5 clk = ~clk;

    typedef struct {
        int hf, hs, hb, hv, vv, vf, vs, vb, d;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int h, v;
        bit vis, eol, eof, hs, vs, de;
    } exp_t;

    logic [3:0][11:0] hc;
    logic [3:0]       v0, v1, v2;
    logic [2:0]       v3;
    logic [3:0]       vis, eol, eof, hs, vs, de;
    logic [3:0][15:0] fc;

    video_timing #(.H_FRONT(16), .H_SYNC(96), .H_BACK(48), .H_VISIBLE(640),
                   .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .SYNC_DELAY(4)) u0 (
        .clk(clk), .reset(rst[0]), .h_count_o(hc[0]), .v_count_o(v0),
        .v_visible_o(vis[0]), .end_of_line_o(eol[0]),
        .end_of_frame_o(eof[0]), .frame_count_o(fc[0]),
        .hsync_o(hs[0]), .vsync_o(vs[0]), .dv_de_o(de[0]));

    video_timing #(.H_FRONT(16), .H_SYNC(96), .H_BACK(48), .H_VISIBLE(640),
                   .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .SYNC_DELAY(1)) u1 (
        .clk(clk), .reset(rst[1]), .h_count_o(hc[1]), .v_count_o(v1),
        .v_visible_o(vis[1]), .end_of_line_o(eol[1]),
        .end_of_frame_o(eof[1]), .frame_count_o(fc[1]),
        .hsync_o(hs[1]), .vsync_o(vs[1]), .dv_de_o(de[1]));

    video_timing #(.H_FRONT(16), .H_SYNC(96), .H_BACK(48), .H_VISIBLE(640),
                   .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .SYNC_DELAY(8)) u2 (
        .clk(clk), .reset(rst[2]), .h_count_o(hc[2]), .v_count_o(v2),
        .v_visible_o(vis[2]), .end_of_line_o(eol[2]),
        .end_of_frame_o(eof[2]), .frame_count_o(fc[2]),
        .hsync_o(hs[2]), .vsync_o(vs[2]), .dv_de_o(de[2]));

    video_timing #(.H_FRONT(1), .H_SYNC(1), .H_BACK(1), .H_VISIBLE(8),
                   .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .SYNC_DELAY(4)) u3 (
        .clk(clk), .reset(rst[3]), .h_count_o(hc[3]), .v_count_o(v3),
        .v_visible_o(vis[3]), .end_of_line_o(eol[3]),
        .end_of_frame_o(eof[3]), .frame_count_o(fc[3]),
        .hsync_o(hs[3]), .vsync_o(vs[3]), .dv_de_o(de[3]));

    function automatic cfg_t cfg_of(int k);
        cfg_t c;
        c.hf = 16; c.hs = 96; c.hb = 48; c.hv = 640;
        c.vv = 4;  c.vf = 2;  c.vs = 2;  c.vb = 3;
        c.d = 4;   c.hp = 1'b0; c.vp = 1'b0;
        if (k == 1) begin c.d = 1; c.hp = 1'b1; end
        if (k == 2) begin c.d = 8; c.vp = 1'b1; end
        if (k == 3) begin
            c.hf = 1; c.hs = 1; c.hb = 1; c.hv = 8;
            c.vv = 2; c.vf = 1; c.vs = 1; c.vb = 1;
        end
        return c;
    endfunction

    // Position p = active clocks since reset; everything follows from it.
    function automatic exp_t model(cfg_t c, longint p);
        exp_t   e;
        longint hoff, ht, vt, q, hq, vq;
        hoff  = c.hf + c.hs + c.hb;
        ht    = hoff + c.hv;
        vt    = c.vv + c.vf + c.vs + c.vb;
        e.h   = int'(p % ht);
        e.v   = int'((p / ht) % vt);
        e.vis = (e.v < c.vv);
        e.eol = (e.h == ht - 1);
        e.eof = e.eol && (e.v == vt - 1);
        e.hs  = !c.hp;
        e.vs  = !c.vp;
        e.de  = 1'b0;
        if (p >= c.d) begin
            q  = p - c.d;
            hq = q % ht;
            vq = (q / ht) % vt;
            if (hq >= c.hf && hq < c.hf + c.hs) e.hs = c.hp;
            if (vq >= c.vv + c.vf && vq < c.vv + c.vf + c.vs) e.vs = c.vp;
            e.de = (hq >= hoff) && (vq < c.vv);
        end
        return e;
    endfunction

    longint pm [4];
    int     fm [4];
    bit     armed [4];
    int     ovr_seq = 0;
    int     ovr_seen = 0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            pm[k] = 0; fm[k] = 0; armed[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            automatic exp_t e = model(cfg_of(k), pm[k]);
            automatic int   f = fm[k];
            if (k == 3 && ovr_seq != ovr_seen) f = 16'hFFFF;
            if (rst[k]) begin
                pm[k] <= 0; fm[k] <= 0; armed[k] <= 1'b1;
            end else if (armed[k]) begin
                pm[k] <= pm[k] + 1;
                fm[k] <= e.eof ? ((f + 1) & 16'hFFFF) : f;
            end
        end
        ovr_seen <= ovr_seq;
    end

    int     lph [64];
    int     ldut [64];
    longint lp [64];
    int     lsig [64];
    int     lval [64];
    int     nl = 0;
    int     phase = 0;
    bit     done = 1'b0;

    task automatic add(int ph, int k, longint p, int s, int v);
        lph[nl] = ph; ldut[nl] = k; lp[nl] = p; lsig[nl] = s; lval[nl] = v;
        nl++;
    endtask

    int     n_checks = 0;
    int     n_fail = 0;
    int     li = 0;
    int     cyc = 0;
    int     cnt_de = 0;
    int     cnt_eol = 0;
    int     cnt_vis = 0;
    longint lastp = -1;

    function automatic int get(int k, int s);
        case (s)
            0: return int'(hc[k]);
            1: return (k == 0) ? int'(v0) : (k == 1) ? int'(v1) :
                      (k == 2) ? int'(v2) : int'(v3);
            2: return int'(eol[k]);
            3: return int'(eof[k]);
            4: return int'(hs[k]);
            5: return int'(vs[k]);
            6: return int'(de[k]);
            7: return int'(fc[k]);
            8: return int'(vis[k]);
            9: return cnt_de;
            10: return cnt_eol;
            11: return cnt_vis;
            default: return -1;
        endcase
    endfunction

    task automatic chk(int k, string nm, longint p, longint act, longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL u%0d %s p=%0d got=%0d exp=%0d", k, nm, p, act, exp_v);
        end
    endtask

    task automatic cmp(int k, int h, int v, bit vi, bit el, bit ef,
                       int f, bit hsy, bit vsy, bit dde);
        exp_t e = model(cfg_of(k), pm[k]);
        chk(k, "h_count", pm[k], h, e.h);
        chk(k, "v_count", pm[k], v, e.v);
        chk(k, "v_visible", pm[k], vi, e.vis);
        chk(k, "end_of_line", pm[k], el, e.eol);
        chk(k, "end_of_frame", pm[k], ef, e.eof);
        chk(k, "frame_count", pm[k], f, fm[k]);
        chk(k, "hsync", pm[k], hsy, e.hs);
        chk(k, "vsync", pm[k], vsy, e.vs);
        chk(k, "dv_de", pm[k], dde, e.de);
    endtask

    // Single compare process: model checks, literal schedule, summary.
    always @(negedge clk) begin
        cyc++;
        if (phase == 1 && armed[0] && pm[0] < 8800 && pm[0] != lastp) begin
            lastp = pm[0];
            cnt_de  += int'(de[0]);
            cnt_eol += int'(eol[0]);
            cnt_vis += int'(vis[0]);
        end
        if (armed[0]) cmp(0, int'(hc[0]), int'(v0), vis[0], eol[0], eof[0],
                          int'(fc[0]), hs[0], vs[0], de[0]);
        if (armed[1]) cmp(1, int'(hc[1]), int'(v1), vis[1], eol[1], eof[1],
                          int'(fc[1]), hs[1], vs[1], de[1]);
        if (armed[2]) cmp(2, int'(hc[2]), int'(v2), vis[2], eol[2], eof[2],
                          int'(fc[2]), hs[2], vs[2], de[2]);
        if (armed[3]) cmp(3, int'(hc[3]), int'(v3), vis[3], eol[3], eof[3],
                          int'(fc[3]), hs[3], vs[3], de[3]);
        while (li < nl && phase == lph[li] && armed[ldut[li]] &&
               pm[ldut[li]] == lp[li]) begin
            chk(ldut[li], $sformatf("literal%0d", li), lp[li],
                get(ldut[li], lsig[li]), lval[li]);
            li++;
        end
        if (done || cyc > 80000) begin
            n_checks++;
            if (li != nl || !done) begin
                n_fail++;
                $display("FAIL schedule reached=%0d required=%0d done=%0d",
                         li, nl, done);
            end
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $finish;
        end
    end

    task automatic wait_p(int k, longint t);
        int n = 0;
        while (pm[k] != t && n < 20000) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    initial begin
        add(1, 0, 0, 0, 0);    add(1, 0, 0, 1, 0);    add(1, 0, 0, 7, 0);
        add(1, 0, 0, 4, 1);    add(1, 0, 0, 5, 1);    add(1, 0, 0, 6, 0);
        add(1, 0, 0, 8, 1);    add(1, 0, 0, 2, 0);    add(1, 0, 0, 3, 0);
        add(1, 0, 1, 0, 1);
        add(1, 0, 19, 4, 1);   add(1, 0, 20, 4, 0);
        add(1, 0, 115, 4, 0);  add(1, 0, 116, 4, 1);
        add(1, 0, 163, 6, 0);  add(1, 0, 164, 6, 1);
        add(1, 0, 799, 2, 1);  add(1, 0, 799, 0, 799);
        add(1, 0, 800, 0, 0);  add(1, 0, 800, 1, 1);  add(1, 0, 800, 2, 0);
        add(1, 0, 803, 6, 1);  add(1, 0, 804, 6, 0);
        add(1, 0, 4803, 5, 1); add(1, 0, 4804, 5, 0);
        add(1, 0, 6403, 5, 0); add(1, 0, 6404, 5, 1);
        add(1, 0, 8799, 3, 1); add(1, 0, 8799, 2, 1);
        add(1, 0, 8799, 1, 10);
        add(1, 0, 8800, 0, 0); add(1, 0, 8800, 1, 0); add(1, 0, 8800, 7, 1);
        add(1, 0, 8800, 9, 2560); add(1, 0, 8800, 10, 11);
        add(1, 0, 8800, 11, 3200);
        add(1, 3, 8801, 7, 65535); add(1, 3, 8854, 3, 1);
        add(1, 3, 8854, 7, 65535); add(1, 3, 8855, 7, 0);
        add(1, 3, 8855, 0, 0);     add(1, 3, 8855, 1, 0);
        add(2, 0, 4900, 5, 0);     add(2, 2, 4900, 5, 1);
        add(3, 0, 0, 5, 1); add(3, 1, 0, 5, 1); add(3, 2, 0, 5, 0);
        add(3, 0, 0, 4, 1); add(3, 1, 0, 4, 0); add(3, 2, 0, 4, 1);
        add(3, 0, 0, 6, 0); add(3, 1, 0, 6, 0); add(3, 2, 0, 6, 0);
        add(4, 1, 16, 4, 0); add(4, 1, 17, 4, 1);
        add(4, 0, 19, 4, 1); add(4, 0, 20, 4, 0);
        add(4, 2, 23, 4, 1); add(4, 2, 24, 4, 0);

        repeat ($urandom_range(3, 12)) @(negedge clk);
        #1 rst = 4'b1111;
        phase = 1;
        repeat (3) @(negedge clk);
        #1 rst = 4'b0000;

        wait_p(0, 8800);
        force u3.frame_q = 16'hFFFF;
        ovr_seq++;
        @(negedge clk);
        #1 release u3.frame_q;
        wait_p(3, 8856);
        phase = 2;

        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(40, 2000)) @(negedge clk);
            #1 rst = 4'($urandom_range(1, 15));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #1 rst = 4'b0000;
        end

        for (int n = 0; n < 200 && (pm[3] % 55) != 54; n++) @(negedge clk);
        #1 rst[3] = 1'b1;
        @(negedge clk);
        #1 rst[3] = 1'b0;

        rst = rst | 4'b0111;
        repeat (2) @(negedge clk);
        #1 rst = rst & 4'b1000;
        wait_p(0, 4900);
        phase = 3;
        rst = rst | 4'b0111;
        repeat (3) @(negedge clk);
        #1 rst = rst & 4'b1000;
        phase = 4;
        wait_p(0, 30);
        done = 1'b1;
    end

endmodule
